// File: rtl/sobel_edge_detector.sv
// Streaming 3x3 Sobel edge detector: two line buffers feed a sliding window,
// one result per interior pixel with saturated |Gx|+|Gy| and a threshold flag.
module sobel_edge_detector #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] DataIn,
  input  logic [7:0] Threshold,
  output logic       Finish,
  output logic       isReady,
  output logic       Dop,
  output logic [7:0] Gradient,
  output logic [1:0] debug_current_state,
  output logic [7:0] debug_Out_Row,
  output logic [7:0] debug_Out_Column
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PROCESS = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          flush;
  logic          win_valid;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;
  logic          sample;

  logic [7:0] lb0 [2**CW];
  logic [7:0] lb1 [2**CW];
  logic [7:0] w   [3][3];

  logic [10:0]        pos_x, neg_x, pos_y, neg_y, diff_x, diff_y, ax, ay;
  logic signed [10:0] gx, gy;
  logic [11:0]        mag;
  logic [7:0]         grad_sat;

  assign sample              = (state == LOAD) || (state == PROCESS && !flush);
  assign Finish              = (state == IDLE) || (state == DONE);
  assign debug_current_state = state;

  // lb0 holds row r-2 and lb1 row r-1 at the column being sampled
  always_ff @(posedge CLK) begin
    if (sample) begin
      lb0[col] <= lb1[col];
      lb1[col] <= DataIn;
      w[0][0]  <= w[0][1];
      w[0][1]  <= w[0][2];
      w[0][2]  <= lb0[col];
      w[1][0]  <= w[1][1];
      w[1][1]  <= w[1][2];
      w[1][2]  <= lb1[col];
      w[2][0]  <= w[2][1];
      w[2][1]  <= w[2][2];
      w[2][2]  <= DataIn;
    end
  end

  always_comb begin
    pos_x    = 11'(w[0][2]) + 11'({w[1][2], 1'b0}) + 11'(w[2][2]);
    neg_x    = 11'(w[0][0]) + 11'({w[1][0], 1'b0}) + 11'(w[2][0]);
    pos_y    = 11'(w[2][0]) + 11'({w[2][1], 1'b0}) + 11'(w[2][2]);
    neg_y    = 11'(w[0][0]) + 11'({w[0][1], 1'b0}) + 11'(w[0][2]);
    diff_x   = pos_x - neg_x;
    diff_y   = pos_y - neg_y;
    gx       = $signed(diff_x);
    gy       = $signed(diff_y);
    ax       = gx[10] ? (neg_x - pos_x) : diff_x;
    ay       = gy[10] ? (neg_y - pos_y) : diff_y;
    mag      = 12'(ax) + 12'(ay);
    grad_sat = (mag > 12'd255) ? 8'hFF : mag[7:0];
  end

  // Window completion is flagged on the sampling edge and the result is
  // registered one edge later; the extra flush edge in PROCESS lets the last
  // result land on the same edge that enters DONE.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state            <= IDLE;
      row              <= '0;
      col              <= '0;
      flush            <= 1'b0;
      win_valid        <= 1'b0;
      win_row          <= '0;
      win_col          <= '0;
      isReady          <= 1'b0;
      Dop              <= 1'b0;
      Gradient         <= '0;
      debug_Out_Row    <= '0;
      debug_Out_Column <= '0;
    end else begin
      isReady   <= win_valid;
      win_valid <= sample && (row > RW'(1)) && (col > CW'(1));
      if (win_valid) begin
        Gradient         <= grad_sat;
        Dop              <= (grad_sat > Threshold);
        debug_Out_Row    <= 8'(win_row);
        debug_Out_Column <= 8'(win_col);
      end
      if (sample) begin
        win_row <= row - RW'(1);
        win_col <= col - CW'(1);
        if (col == LAST_COL) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      case (state)
        IDLE: begin
          if (Start) begin
            state <= LOAD;
            row   <= '0;
            col   <= '0;
          end
        end
        LOAD: begin
          if (row == RW'(2) && col == CW'(1)) state <= PROCESS;
        end
        PROCESS: begin
          if (flush) begin
            flush <= 1'b0;
            state <= DONE;
          end else if (row == LAST_ROW && col == LAST_COL) begin
            flush <= 1'b1;
          end
        end
        DONE: begin
          if (!Start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_edge_detector.sv
// Bench for sobel_edge_detector on a reduced 16x10 image: a 2-D reference of the
// Sobel operator produces the expected result stream, checked on every isReady cycle.
module tb_sobel_edge_detector;

  localparam int W = 16;
  localparam int H = 10;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] DataIn;
  logic [7:0] Threshold;
  logic       Finish;
  logic       isReady;
  logic       Dop;
  logic [7:0] Gradient;
  logic [1:0] debug_current_state;
  logic [7:0] debug_Out_Row;
  logic [7:0] debug_Out_Column;

  sobel_edge_detector #(.WIDTH(W), .HEIGHT(H)) dut (
    .CLK                 (CLK),
    .Reset               (Reset),
    .Start               (Start),
    .DataIn              (DataIn),
    .Threshold           (Threshold),
    .Finish              (Finish),
    .isReady             (isReady),
    .Dop                 (Dop),
    .Gradient            (Gradient),
    .debug_current_state (debug_current_state),
    .debug_Out_Row       (debug_Out_Row),
    .debug_Out_Column    (debug_Out_Column)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int row;
    int col;
    int grad;
    int dop;
  } res_t;

  int   img [H][W];
  res_t exp_q[$];
  res_t cur;
  int   checks = 0;
  int   errors = 0;
  bit   check_en = 1'b0;
  int   seen, first_row, first_col, last_row, last_col;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int idx(input int r, input int c);
    return (r - 1) * (W - 2) + (c - 1);
  endfunction

  function automatic void build_expected(input int thr);
    exp_q.delete();
    for (int r = 1; r < H - 1; r++) begin
      for (int c = 1; c < W - 1; c++) begin
        int gx, gy, m;
        res_t e;
        gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
        e.row  = r;
        e.col  = c;
        e.grad = m;
        e.dop  = (m > thr) ? 1 : 0;
        exp_q.push_back(e);
      end
    end
  endfunction

  always @(negedge CLK) begin
    if (check_en && !Reset && isReady) begin
      if (exp_q.size() == 0) begin
        chk("extra_result", 1, 0);
      end else begin
        cur = exp_q.pop_front();
        chk("gradient", int'(Gradient), cur.grad);
        chk("dop", int'(Dop), cur.dop);
        chk("out_row", int'(debug_Out_Row), cur.row);
        chk("out_col", int'(debug_Out_Column), cur.col);
        if (seen == 0) begin
          first_row = int'(debug_Out_Row);
          first_col = int'(debug_Out_Column);
        end
        last_row = int'(debug_Out_Row);
        last_col = int'(debug_Out_Column);
        seen++;
        if (exp_q.size() == 0) chk("last_in_done", int'(debug_current_state), 3);
      end
    end
  end

  task automatic run_frame(input int thr, input bit hold_start);
    int n;
    build_expected(thr);
    Threshold = 8'(thr);
    seen      = 0;
    check_en  = 1'b1;
    @(negedge CLK);
    Start = 1'b1;
    @(negedge CLK);
    chk("state_load", int'(debug_current_state), 1);
    chk("finish_busy", int'(Finish), 0);
    if (!hold_start) Start = 1'b0;
    for (int i = 0; i < W * H; i++) begin
      DataIn = 8'(img[i / W][i % W]);
      @(negedge CLK);
    end
    DataIn = 8'($urandom_range(0, 255));
    n = 0;
    while (debug_current_state != 2'd3 && n < 8) begin
      @(negedge CLK);
      n++;
    end
    chk("reach_done", int'(debug_current_state), 3);
    chk("finish_done", int'(Finish), 1);
    @(negedge CLK);
    chk("ready_off_after_done", int'(isReady), 0);
    chk("result_count", seen, (W - 2) * (H - 2));
    chk("queue_drained", exp_q.size(), 0);
    chk("first_row", first_row, 1);
    chk("first_col", first_col, 1);
    chk("last_row", last_row, H - 2);
    chk("last_col", last_col, W - 2);
    if (hold_start) begin
      repeat (3) @(negedge CLK);
      chk("hold_in_done", int'(debug_current_state), 3);
      Start = 1'b0;
    end
    @(negedge CLK);
    chk("back_to_idle", int'(debug_current_state), 0);
    check_en = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, int'(debug_current_state), 0);
    chk({tag, "_finish"}, int'(Finish), 1);
    chk({tag, "_ready"}, int'(isReady), 0);
    chk({tag, "_gradient"}, int'(Gradient), 0);
    chk({tag, "_dop"}, int'(Dop), 0);
    chk({tag, "_row"}, int'(debug_Out_Row), 0);
    chk({tag, "_col"}, int'(debug_Out_Column), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int thr;
    Reset     = 1'b1;
    Start     = 1'b0;
    DataIn    = '0;
    Threshold = '0;
    repeat (2) @(negedge CLK);
    check_reset_values("reset");
    Reset = 1'b0;

    // Flat image
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 100;
    build_expected(10);
    chk("model_flat", exp_q[idx(1, 1)].grad, 0);
    run_frame(10, 1'b0);

    // Vertical step at the middle column
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c < W / 2) ? 0 : 255;
    build_expected(10);
    chk("model_step_left", exp_q[idx(1, W/2 - 1)].grad, 255);
    chk("model_step_right", exp_q[idx(3, W/2)].grad, 255);
    chk("model_step_dop", exp_q[idx(1, W/2 - 1)].dop, 1);
    chk("model_step_flat_l", exp_q[idx(2, W/2 - 2)].grad, 0);
    chk("model_step_flat_r", exp_q[idx(2, W/2 + 1)].grad, 0);
    run_frame(10, 1'b0);

    // Horizontal ramp: Gx = 8, Gy = 0 everywhere
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = c;
    build_expected(8);
    chk("model_ramp_grad", exp_q[idx(2, 5)].grad, 8);
    chk("model_ramp_dop8", exp_q[idx(2, 5)].dop, 0);
    run_frame(8, 1'b1);
    build_expected(7);
    chk("model_ramp_dop7", exp_q[idx(4, 9)].dop, 1);
    run_frame(7, 1'b0);

    // Random images, full range and low contrast
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          img[r][c] = (k == 2) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 255));
      thr = (k == 2) ? int'($urandom_range(0, 100)) : int'($urandom_range(0, 255));
      run_frame(thr, k == 1);
    end

    // Reset in the middle of PROCESS, then a clean rerun of the same image
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
    thr       = int'($urandom_range(0, 200));
    Threshold = 8'(thr);
    @(negedge CLK);
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    for (int i = 0; i < 3 * W + 5; i++) begin
      DataIn = 8'(img[i / W][i % W]);
      @(negedge CLK);
    end
    chk("midframe_in_process", int'(debug_current_state), 2);
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset_values("midreset");
    Reset = 1'b0;
    run_frame(thr, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
